// File: rtl/bp_burst_mem_responder_pkg.sv
// Shared definitions for the burst memory responder: message types, header
// width and the size-derived helpers used by the command/response datapath.
package bp_burst_mem_responder_pkg;

  // Message types understood by the responder; any other code is answered
  // with a bare response header.
  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  // Header layout is {msg_type[3:0], addr, size[2:0], payload}.
  function automatic int bp_hdr_width(input int paddr_width, input int payload_width);
    return 4 + paddr_width + 3 + payload_width;
  endfunction

  // Beats in a message minus one: sub-dword and dword sizes take one beat,
  // larger sizes take 2^(size-3) beats of 64 bits.
  function automatic logic [3:0] bp_beat_cnt_init(input logic [2:0] size);
    logic [3:0] cnt;
    case (size)
      3'd4:    cnt = 4'd1;
      3'd5:    cnt = 4'd3;
      3'd6:    cnt = 4'd7;
      3'd7:    cnt = 4'd15;
      default: cnt = 4'd0;
    endcase
    return cnt;
  endfunction

  // Byte lanes touched by a write: full word for size>=3, otherwise the
  // 2^size bytes starting at the byte offset inside the word.
  function automatic logic [7:0] bp_byte_mask(input logic [2:0] size, input logic [2:0] offset);
    logic [7:0] mask;
    case (size)
      3'd0:    mask = 8'h01 << offset;
      3'd1:    mask = 8'h03 << offset;
      3'd2:    mask = 8'h0F << offset;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  function automatic logic bp_is_read(input logic [3:0] msg_type);
    return (msg_type == e_bedrock_mem_rd) || (msg_type == e_bedrock_mem_uc_rd);
  endfunction

  function automatic logic bp_is_write(input logic [3:0] msg_type);
    return (msg_type == e_bedrock_mem_wr) || (msg_type == e_bedrock_mem_uc_wr);
  endfunction

endpackage

// File: rtl/bp_burst_mem_responder_mem.sv
// Single-port word RAM in the bsg_mem_1rw_sync_mask_write_byte mould:
// synchronous read with one cycle of latency, byte-masked write. The read
// port register only changes on a read, so it holds its word across idle
// and write cycles. Contents are never reset.
module bp_burst_mem_responder_mem #(
  parameter int width_p = 64,
  parameter int els_p   = 1024,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                   clk_i,
  input  logic                   v_i,
  input  logic                   w_i,
  input  logic [lg_els_lp-1:0]   addr_i,
  input  logic [width_p-1:0]     data_i,
  input  logic [width_p/8-1:0]   write_mask_i,
  output logic [width_p-1:0]     data_o
);

  logic [width_p-1:0] mem [els_p];

  // Byte-masked write or registered read, one access per cycle.
  always_ff @(posedge clk_i) begin
    if (v_i && w_i) begin
      for (int i = 0; i < width_p/8; i++) begin
        if (write_mask_i[i]) begin
          mem[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
        end
      end
    end
    if (v_i && !w_i) begin
      data_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/bp_burst_mem_responder.sv
// Burst-protocol memory responder. Accepts a command header (plus write
// beats), answers with a response header (plus read beats) from an internal
// word RAM. One message is in flight at a time; the command and response
// sides never overlap.
module bp_burst_mem_responder
  import bp_burst_mem_responder_pkg::*;
#(
  parameter int paddr_width_p   = 40,
  parameter int payload_width_p = 32,
  parameter int data_width_p    = 64,
  parameter int els_p           = 1024,
  parameter int max_size_p      = 6,
  localparam int hdr_width_lp   = bp_hdr_width(paddr_width_p, payload_width_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic [hdr_width_lp-1:0]  mem_cmd_header_i,
  input  logic                     mem_cmd_header_v_i,
  output logic                     mem_cmd_header_ready_and_o,
  input  logic [data_width_p-1:0]  mem_cmd_data_i,
  input  logic                     mem_cmd_data_v_i,
  output logic                     mem_cmd_data_ready_and_o,

  output logic [hdr_width_lp-1:0]  mem_resp_header_o,
  output logic                     mem_resp_header_v_o,
  input  logic                     mem_resp_header_ready_and_i,
  output logic [data_width_p-1:0]  mem_resp_data_o,
  output logic                     mem_resp_data_v_o,
  input  logic                     mem_resp_data_ready_and_i
);

  localparam int lg_els_lp   = $clog2(els_p);
  localparam int mask_width_lp = data_width_p / 8;
  localparam logic [2:0] max_size_lp = 3'(max_size_p);

  typedef struct packed {
    logic [3:0]                 msg_type;
    logic [paddr_width_p-1:0]   addr;
    logic [2:0]                 size;
    logic [payload_width_p-1:0] payload;
  } bp_hdr_s;

  typedef logic [lg_els_lp-1:0] idx_t;

  localparam logic [2:0] READY      = 3'd0;
  localparam logic [2:0] WR_DATA    = 3'd1;
  localparam logic [2:0] WR_RESP    = 3'd2;
  localparam logic [2:0] RD_RESP    = 3'd3;
  localparam logic [2:0] RD_DATA    = 3'd4;
  localparam logic [2:0] OTHER_RESP = 3'd5;

  logic [2:0]              state_r;
  bp_hdr_s                 hdr_r;
  logic [3:0]              beat_cnt_r;
  idx_t                    idx_r;
  logic [data_width_p-1:0] out_r;
  logic                    rd_fresh_r;

  bp_hdr_s cmd_hdr;
  idx_t    cmd_idx;
  logic    hdr_hs, data_hs, resp_hdr_hs, resp_data_hs;

  logic                     ram_v, ram_w;
  idx_t                     ram_addr;
  logic [data_width_p-1:0]  ram_wdata, ram_rdata;
  logic [mask_width_lp-1:0] ram_mask;

  assign cmd_hdr = mem_cmd_header_i;
  assign cmd_idx = cmd_hdr.addr[3 +: lg_els_lp];

  // Readies and valids come from the state alone and are forced low while
  // reset is asserted, so nothing is offered or accepted during reset.
  always_comb begin
    mem_cmd_header_ready_and_o = ~reset_i & (state_r == READY);
    mem_cmd_data_ready_and_o   = ~reset_i & (state_r == WR_DATA);
    mem_resp_header_v_o        = ~reset_i & ((state_r == WR_RESP) || (state_r == RD_RESP)
                                             || (state_r == OTHER_RESP));
    mem_resp_data_v_o          = ~reset_i & (state_r == RD_DATA);
  end

  assign hdr_hs       = mem_cmd_header_v_i & mem_cmd_header_ready_and_o;
  assign data_hs      = mem_cmd_data_v_i & mem_cmd_data_ready_and_o;
  assign resp_hdr_hs  = mem_resp_header_v_o & mem_resp_header_ready_and_i;
  assign resp_data_hs = mem_resp_data_v_o & mem_resp_data_ready_and_i;

  assign mem_resp_header_o = hdr_r;

  // The word just read appears on the RAM port one cycle after the read is
  // issued; forward it straight out that cycle and keep a copy so the beat
  // stays stable while the requester stalls.
  assign mem_resp_data_o = rd_fresh_r ? ram_rdata : out_r;

  // RAM access steering: first read on a read header, one write per accepted
  // write beat, and the next read on every read beat that is not the last.
  always_comb begin
    ram_v     = 1'b0;
    ram_w     = 1'b0;
    ram_addr  = idx_r;
    ram_wdata = mem_cmd_data_i;
    ram_mask  = '0;
    if (hdr_hs && bp_is_read(cmd_hdr.msg_type)) begin
      ram_v    = 1'b1;
      ram_addr = cmd_idx;
    end else if (data_hs) begin
      ram_v    = 1'b1;
      ram_w    = 1'b1;
      ram_mask = bp_byte_mask(hdr_r.size, hdr_r.addr[2:0]);
    end else if (resp_data_hs && (beat_cnt_r != 4'd0)) begin
      ram_v    = 1'b1;
      ram_addr = idx_r + idx_t'(1);
    end
  end

  bp_burst_mem_responder_mem #(
    .width_p (data_width_p),
    .els_p   (els_p)
  ) ram (
    .clk_i        (clk_i),
    .v_i          (ram_v),
    .w_i          (ram_w),
    .addr_i       (ram_addr),
    .data_i       (ram_wdata),
    .write_mask_i (ram_mask),
    .data_o       (ram_rdata)
  );

  // Output register: remember whether a read was issued last cycle and
  // capture that word so it can be replayed under backpressure.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_fresh_r <= 1'b0;
      out_r      <= '0;
    end else begin
      rd_fresh_r <= ram_v & ~ram_w;
      if (rd_fresh_r) begin
        out_r <= ram_rdata;
      end
    end
  end

  // Message sequencer: latches the header, walks the word index and beat
  // count, and returns to READY after the final response transfer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= READY;
      hdr_r      <= '0;
      beat_cnt_r <= '0;
      idx_r      <= '0;
    end else begin
      case (state_r)
        READY: begin
          if (hdr_hs) begin
            hdr_r      <= cmd_hdr;
            beat_cnt_r <= bp_beat_cnt_init(cmd_hdr.size);
            idx_r      <= cmd_idx;
            if (bp_is_read(cmd_hdr.msg_type)) begin
              state_r <= RD_RESP;
            end else if (bp_is_write(cmd_hdr.msg_type)) begin
              state_r <= WR_DATA;
            end else begin
              state_r <= OTHER_RESP;
            end
          end
        end
        WR_DATA: begin
          if (data_hs) begin
            idx_r <= idx_r + idx_t'(1);
            if (beat_cnt_r == 4'd0) begin
              state_r <= WR_RESP;
            end else begin
              beat_cnt_r <= beat_cnt_r - 4'd1;
            end
          end
        end
        WR_RESP, OTHER_RESP: begin
          if (resp_hdr_hs) begin
            state_r <= READY;
          end
        end
        RD_RESP: begin
          if (resp_hdr_hs) begin
            state_r <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (resp_data_hs) begin
            if (beat_cnt_r == 4'd0) begin
              state_r <= READY;
            end else begin
              idx_r      <= idx_r + idx_t'(1);
              beat_cnt_r <= beat_cnt_r - 4'd1;
            end
          end
        end
        default: state_r <= READY;
      endcase
    end
  end

  // Sizes above the configured maximum have no defined behaviour.
  illegal_size_a: assert property (@(posedge clk_i) disable iff (reset_i)
    hdr_hs |-> (cmd_hdr.size <= max_size_lp));

endmodule

// File: tb/tb_bp_burst_mem_responder.sv
// Self-checking bench for the burst memory responder: directed scenarios
// plus randomized traffic against a word-array memory model.
module tb_bp_burst_mem_responder;

  localparam int hdr_w = 79;
  localparam int els   = 1024;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [hdr_w-1:0]  cmd_header;
  logic              cmd_header_v;
  logic              cmd_header_ready;
  logic [63:0]       cmd_data;
  logic              cmd_data_v;
  logic              cmd_data_ready;
  logic [hdr_w-1:0]  resp_header;
  logic              resp_header_v;
  logic              resp_header_ready;
  logic [63:0]       resp_data;
  logic              resp_data_v;
  logic              resp_data_ready;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] ref_mem [els];
  logic [63:0] wr_beats [$];

  bp_burst_mem_responder dut (
    .clk_i                       (clk_i),
    .reset_i                     (reset_i),
    .mem_cmd_header_i            (cmd_header),
    .mem_cmd_header_v_i          (cmd_header_v),
    .mem_cmd_header_ready_and_o  (cmd_header_ready),
    .mem_cmd_data_i              (cmd_data),
    .mem_cmd_data_v_i            (cmd_data_v),
    .mem_cmd_data_ready_and_o    (cmd_data_ready),
    .mem_resp_header_o           (resp_header),
    .mem_resp_header_v_o         (resp_header_v),
    .mem_resp_header_ready_and_i (resp_header_ready),
    .mem_resp_data_o             (resp_data),
    .mem_resp_data_v_o           (resp_data_v),
    .mem_resp_data_ready_and_i   (resp_data_ready)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return cmd_header_ready;
      1:       return cmd_data_ready;
      2:       return resp_header_v;
      default: return resp_data_v;
    endcase
  endfunction

  // Called at a falling edge; waits a bounded number of cycles for a signal.
  task automatic wait_sig(input int which, input string tag);
    int n = 0;
    while (!sig(which) && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    if (!sig(which)) begin
      checkOutput(tag, 128'(sig(which)), 128'd1);
      finish_run();
    end
  endtask

  // Memory model: the byte range a write covers, applied to word (index+beat).
  task automatic model_write(input logic [39:0] addr, input logic [2:0] size,
                             input int beat, input logic [63:0] data);
    int lo, nbytes;
    logic [9:0] w;
    w      = 10'(int'(addr[12:3]) + beat);
    lo     = (size < 3) ? int'(addr[2:0]) : 0;
    nbytes = (size < 3) ? (1 << size) : 8;
    for (int b = 0; b < 8; b++) begin
      if (b >= lo && b < lo + nbytes) ref_mem[w][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  // One complete message: command side, response header, read beats.
  // rmode: 0 ready held high, 1 ready pattern 1,0,0,..., 2 random ready.
  task automatic applyStimulus(input logic [3:0] mtype, input logic [39:0] addr,
                               input logic [2:0] size, input logic [31:0] payload,
                               input int rmode);
    logic [hdr_w-1:0] hdr;
    logic [63:0]      wd;
    logic [9:0]       w;
    int beats, got, cyc;
    bit is_rd, is_wr, r;
    hdr   = {mtype, addr, size, payload};
    beats = (size < 3) ? 1 : (1 << (int'(size) - 3));
    is_rd = (mtype == 4'd0) || (mtype == 4'd2);
    is_wr = (mtype == 4'd1) || (mtype == 4'd3);

    @(negedge clk_i);
    cmd_header   = hdr;
    cmd_header_v = 1'b1;
    wait_sig(0, "cmd_hdr_ready");
    @(posedge clk_i); #1;
    cmd_header_v = 1'b0;

    if (is_wr) begin
      for (int k = 0; k < beats; k++) begin
        wd = (wr_beats.size() > 0) ? wr_beats.pop_front() : {$urandom, $urandom};
        cmd_data   = wd;
        cmd_data_v = 1'b1;
        @(negedge clk_i);
        wait_sig(1, "cmd_data_ready");
        @(posedge clk_i); #1;
        model_write(addr, size, k, wd);
      end
      cmd_data_v = 1'b0;
    end

    @(negedge clk_i);
    checkOutput("resp_hdr_latency", 128'(resp_header_v), 128'd1);
    wait_sig(2, "resp_hdr_v");
    checkOutput("resp_hdr", 128'(resp_header), 128'(hdr));
    checkOutput("no_data_during_hdr", 128'(resp_data_v), 128'd0);
    @(posedge clk_i); #1;

    if (is_rd) begin
      @(negedge clk_i);
      checkOutput("rd_first_beat_latency", 128'(resp_data_v), 128'd1);
      got = 0;
      cyc = 0;
      while (got < beats && cyc < 100) begin
        case (rmode)
          0:       r = 1'b1;
          1:       r = (cyc % 3 == 0);
          default: r = 1'($urandom);
        endcase
        resp_data_ready = r;
        checkOutput("rd_data_v", 128'(resp_data_v), 128'd1);
        if (resp_data_v) begin
          w = 10'(int'(addr[12:3]) + got);
          checkOutput("rd_beat", 128'(resp_data), 128'(ref_mem[w]));
          if (r) got++;
        end
        cyc++;
        @(negedge clk_i);
      end
      resp_data_ready = 1'b0;
      if (got < beats) begin
        checkOutput("rd_beats_timeout", 128'(got), 128'(beats));
        finish_run();
      end
      if (rmode == 0) checkOutput("rd_throughput", 128'(cyc), 128'(beats));
    end else begin
      @(negedge clk_i);
    end

    checkOutput("back_to_back_ready", 128'(cmd_header_ready), 128'd1);
    checkOutput("no_extra_data", 128'(resp_data_v), 128'd0);
    checkOutput("no_extra_hdr", 128'(resp_header_v), 128'd0);
  endtask

  // Main sequence.
  initial begin
    logic [3:0]  types [8];
    logic [39:0] a;
    logic [2:0]  sz;
    logic [63:0] d;
    types = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd4, 4'd5, 4'd15};

    reset_i           = 1'b1;
    cmd_header        = '0;
    cmd_header_v      = 1'b0;
    cmd_data          = '0;
    cmd_data_v        = 1'b0;
    resp_header_ready = 1'b1;
    resp_data_ready   = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("reset_hdr_ready", 128'(cmd_header_ready), 128'd0);
    checkOutput("reset_data_ready", 128'(cmd_data_ready), 128'd0);
    checkOutput("reset_resp_hdr_v", 128'(resp_header_v), 128'd0);
    checkOutput("reset_resp_data_v", 128'(resp_data_v), 128'd0);
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ready_after_reset", 128'(cmd_header_ready), 128'd1);

    $display("[TB] presetting memory");
    for (int i = 0; i < els / 8; i++) begin
      for (int k = 0; k < 8; k++) wr_beats.push_back({$urandom, $urandom});
      applyStimulus(4'd1, 40'(i * 64), 3'd6, $urandom, 0);
    end

    $display("[TB] 64B write then read");
    for (int k = 0; k < 8; k++) wr_beats.push_back(64'h1000 + 64'(k));
    applyStimulus(4'd1, 40'h80, 3'd6, 32'h0000_0011, 0);
    applyStimulus(4'd0, 40'h80, 3'd6, 32'h0000_0022, 0);

    $display("[TB] byte write");
    wr_beats.push_back(64'h0);
    applyStimulus(4'd1, 40'h100, 3'd3, 32'h33, 0);
    wr_beats.push_back(64'hFFFF_FFFF_AAFF_FFFF);
    applyStimulus(4'd1, 40'h103, 3'd0, 32'h44, 0);
    applyStimulus(4'd2, 40'h100, 3'd3, 32'h55, 0);

    $display("[TB] backpressure read");
    applyStimulus(4'd0, 40'h80, 3'd6, 32'h66, 1);

    $display("[TB] index wrap");
    applyStimulus(4'd0, 40'h1FF8, 3'd4, 32'h77, 0);

    $display("[TB] unknown type");
    applyStimulus(4'd7, 40'h80, 3'd6, 32'hDEAD_BEEF, 0);
    applyStimulus(4'd0, 40'h80, 3'd6, 32'h88, 0);

    $display("[TB] reset mid write");
    @(negedge clk_i);
    cmd_header   = {4'd1, 40'h0, 3'd6, 32'h99};
    cmd_header_v = 1'b1;
    wait_sig(0, "rst_cmd_hdr_ready");
    @(posedge clk_i); #1;
    cmd_header_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d          = {$urandom, $urandom};
      cmd_data   = d;
      cmd_data_v = 1'b1;
      @(negedge clk_i);
      wait_sig(1, "rst_cmd_data_ready");
      @(posedge clk_i); #1;
      model_write(40'h0, 3'd6, k, d);
    end
    cmd_data_v = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("rst_mid_hdr_ready", 128'(cmd_header_ready), 128'd0);
    checkOutput("rst_mid_data_ready", 128'(cmd_data_ready), 128'd0);
    checkOutput("rst_mid_resp_hdr_v", 128'(resp_header_v), 128'd0);
    checkOutput("rst_mid_resp_data_v", 128'(resp_data_v), 128'd0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_release_ready", 128'(cmd_header_ready), 128'd1);
    checkOutput("rst_release_no_resp", 128'(resp_header_v), 128'd0);
    applyStimulus(4'd0, 40'h0, 3'd6, 32'hAB, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) begin
      sz = 3'($urandom_range(0, 6));
      a  = {8'($urandom), 32'($urandom)};
      if (sz < 3) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      applyStimulus(types[$urandom_range(0, 7)], a, sz, $urandom, $urandom_range(0, 2));
    end

    finish_run();
  end

endmodule

// File: doc/bp_burst_mem_responder.md
Name: bp_burst_mem_responder

Overview:
- Memory-side responder for the BedRock burst protocol: consumes burst command header + data beats, returns burst response header + data beats from an internal word RAM.
- Sits at the far end of the burst command/response channels a unicore or burst converter drives.
- Used as a self-contained test memory in tethered benches, so the burst path can be exercised without a lite conversion stage.

Parameters:
- paddr_width_p, 40, physical address width carried in the header.
- payload_width_p, 32, opaque header payload width, returned unchanged.
- data_width_p, 64, beat width; fixed at 64 for this block.
- els_p, 1024, number of 64-bit RAM words; must be a power of 2.
- max_size_p, 6, largest legal log2(bytes) per message, i.e. 64B = 8 beats.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- mem_cmd_header_i  in  hdr_width  {msg_type[3:0], addr[paddr_width_p-1:0], size[2:0], payload}
- mem_cmd_header_v_i  in  1  header valid
- mem_cmd_header_ready_and_o  out  1  header ready
- mem_cmd_data_i  in  64  write data beat
- mem_cmd_data_v_i  in  1  data valid
- mem_cmd_data_ready_and_o  out  1  data ready
- mem_resp_header_o  out  hdr_width  response header, same layout
- mem_resp_header_v_o  out  1  resp header valid
- mem_resp_header_ready_and_i  in  1  resp header ready
- mem_resp_data_o  out  64  read data beat
- mem_resp_data_v_o  out  1  resp data valid
- mem_resp_data_ready_and_i  in  1  resp data ready

Behaviour:
- Handshakes: every channel is ready&valid. A transfer happens in a cycle where both are high. valid must not depend on ready.
- Beat count: beats = (size<3) ? 1 : 2^(size-3).
- Word index: addr[3 +: lg(els_p)]. Advances by 1 per beat and wraps modulo els_p, with no error.
- Message types:
  - 0 rd and 2 uc_rd: read.
  - 1 wr and 3 uc_wr: write.
  - Any other type: header-only response, no RAM effect.
- Write byte mask:
  - size>=3: full mask.
  - size<3: bytes addr[2:0] .. addr[2:0] + 2^size - 1, taken from the same byte lanes of the beat.
- RAM: 1R/1W, synchronous read with 1-cycle latency, byte-mask write. Contents are not reset.
- FSM states: READY, WR_DATA, WR_RESP, RD_RESP, RD_DATA, OTHER_RESP.
- READY:
  - header_ready_and_o=1. On header handshake, latch the header and load beat_cnt = beats-1.
  - read → RD_RESP, and issue the first RAM read in the same cycle.
  - write → WR_DATA.
  - other type → OTHER_RESP.
- WR_DATA:
  - data_ready_and_o=1. Each data handshake writes one word and increments the index.
  - On the last beat (beat_cnt==0) → WR_RESP.
  - Data beats offered in any other state are not accepted.
- WR_RESP / OTHER_RESP:
  - resp_header_v_o=1 carrying the latched header unchanged.
  - On handshake → READY. No response data beats.
- RD_RESP:
  - resp_header_v_o=1. On handshake → RD_DATA.
  - The first RAM word is captured into a 1-entry output register.
- RD_DATA:
  - resp_data_v_o=1 driven from the output register.
  - Each handshake issues the next RAM read; the register refills the next cycle, giving 1 beat/cycle throughput.
  - If ready is low, the register and index hold.
  - After the last beat handshake → READY.
- Sub-dword reads return the full aligned word; the requester selects bytes.
- Latency:
  - Header accept to resp header valid: 1 cycle.
  - Resp header handshake to first data valid: next cycle.
  - Back-to-back messages: a new header is accepted the cycle after the final response transfer (READY is registered).
- Simultaneous events: none possible. Only one channel is active per state; cmd and resp never overlap.
- Reset (asynchronous, including mid-message):
  - State → READY.
  - All valid outputs and ready outputs → 0 while reset_i is high.
  - beat_cnt and output register cleared.
  - Partially written data remains in RAM.
  - The interrupted message gets no response.
- Illegal size > max_size_p: behaviour undefined, flagged by an assertion only.

Decomposition:
- Shared package (bp_me_pkg style):
  - msg type enum.
  - Burst header struct / width macro, parameterised by paddr_width_p and payload_width_p.
  - Beat-count function from size.
- Sub-module: bsg_mem_1rw_sync_mask_write_byte as the RAM; no other sub-modules.
- FSM, beat counter and output register are inline.

Test Plan:
- 64B write then read: wr header addr=0x80, size=6, 8 beats 0x1000..0x1007 → one resp header only.
  - rd addr=0x80 size=6 → header echoed, then 8 beats 0x1000..0x1007 in order, 1/cycle with ready held high.
- Byte write: wr addr=0x103 size=0 data=0xAA in lane 3 over a word preset to 0 → uc_rd addr=0x100 size=3 returns 0x00000000AA000000.
- Backpressure: rd of 8 beats with resp_data ready toggling 1,0,0,1… → beats delivered in order, no duplicate or skipped beats, data stable while ready is low.
- Wrap: els_p=1024, rd addr=0x1FF8*… i.e. index 1023, size=4 → beats from words 1023 then 0.
- Unknown type 7 → one resp header with payload echoed, no data beats, RAM unchanged (verified by a later read).
- Reset asserted after 3 of 8 write beats → outputs drop to 0 immediately. After release, ready is 1 in READY, a new rd gets a correct response, and words 0–2 hold the new data.
